regfile_fwd: RTL and testbench
==============================

Name: regfile_fwd

Overview:
- Integer register file: the consumer end of the write-back triple (wd, wreg, wdata) carried down the pipeline by the EX/MEM and MEM/WB registers.
- Two combinational read ports feed ID stage.
- Forwards in-flight EX and MEM results to ID reads.
- A long-latency-op scoreboard raises a stall request to the stall controller on read-after-write hazards that cannot be forwarded.

Parameters:
DATA_W, 32, register/data width (`RegBus)
ADDR_W, 5, register address width (`RegAddrBus)
NREG, 32, number of registers; register 0 hardwired to zero

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low (asserted when 0)
we  in  1  write-back enable (mem_wb wreg)
waddr  in  ADDR_W  write-back register address
wdata  in  DATA_W  write-back data
re1  in  1  read port 1 enable
raddr1  in  ADDR_W  read port 1 address
rdata1  out  DATA_W  read port 1 data
re2  in  1  read port 2 enable
raddr2  in  ADDR_W  read port 2 address
rdata2  out  DATA_W  read port 2 data
ex_wreg  in  1  EX-stage result will write a register
ex_wd  in  ADDR_W  EX-stage destination
ex_wdata  in  DATA_W  EX-stage result
ex_is_load  in  1  EX-stage instruction is a load (data not yet valid)
mem_wreg  in  1  MEM-stage write enable
mem_wd  in  ADDR_W  MEM-stage destination
mem_wdata  in  DATA_W  MEM-stage result
lat_issue  in  1  long-latency op (mul/div) issued this cycle
lat_wd  in  ADDR_W  its destination register
stallreq  out  1  ID stall request
busy  out  1  any scoreboard bit set

Behaviour:
- Reset (rst=0, async):
  - All NREG registers clear to `ZeroWord.
  - Scoreboard bits clear.
  - While asserted: rdata1/2=0, stallreq=0, busy=0.
- Write:
  - On posedge clk when we=1 and waddr!=0, reg[waddr]<=wdata.
  - Writes to r0 are ignored.
- Read (combinational, zero latency). Per port, priority order:
  1. rst asserted or re=0 -> 0.
  2. raddr=0 -> 0.
  3. ex_wreg && ex_wd==raddr -> ex_wdata.
  4. mem_wreg && mem_wd==raddr -> mem_wdata.
  5. we && waddr==raddr -> wdata (same-cycle write bypass).
  6. Otherwise reg[raddr].
- Load-use stall:
  - stallreq=1 if ex_is_load && ex_wreg && ex_wd!=0 and the EX destination matches an enabled read port's raddr.
  - rdata for that port is still driven (don't-care to consumer).
- Scoreboard (NREG bits, bit 0 never set):
  - lat_issue=1 && lat_wd!=0 sets pending[lat_wd] at posedge.
  - we=1 with pending[waddr] set clears it at posedge.
  - Same-cycle issue and writeback to the same register: set wins (new op outstanding).
  - A second issue to an already-pending register keeps the bit set. No counting; ordering is guaranteed by the pipeline.
- Scoreboard stall:
  - stallreq=1 if an enabled read port hits pending[raddr]=1 and that cycle's write-back (we, waddr) is not writing that register.
  - If the write-back matches, the write bypass supplies the data and there is no stall.
- stallreq = OR of load-use and scoreboard conditions for both ports. Purely combinational from inputs and state; no registered delay.
- busy = |pending.
- Reset mid-operation clears all pending bits. Any write-back arriving after reset deassertion writes the array normally.

Decomposition:
- Shared defines header (existing defines.vh) holds:
  - `RegBus, `RegAddrBus, `ZeroWord, `NOPRegAddr, `WriteEnable/`WriteDisable, `ReadEnable/`ReadDisable.
  - New constant `RegNum = 32.
- One natural sub-module: rf_scoreboard (pending bit vector with set/clear/lookup for two read addresses, returns per-port hit).
- The forward mux is replicated per port inside regfile_fwd.

Test Plan:
- Reset then read: rst=0 for 2 cycles, release; re1=1, raddr1=5 -> rdata1=0, stallreq=0, busy=0.
- Write/read and r0:
  - we=1, waddr=3, wdata=32'hDEADBEEF; next cycle raddr1=3 -> rdata1=32'hDEADBEEF.
  - we=1, waddr=0, wdata=32'h1234; raddr2=0 -> rdata2=0.
- Forward priority:
  - reg[7]=1. Same cycle: ex_wd=7/ex_wdata=2, mem_wd=7/mem_wdata=3, waddr=7/wdata=4 -> rdata1=2.
  - Drop ex_wreg -> rdata1=3.
  - Drop mem_wreg -> rdata1=4.
- Load-use: ex_is_load=1, ex_wreg=1, ex_wd=9, raddr2=9, re2=1 -> stallreq=1. Set re2=0 -> stallreq=0.
- Scoreboard:
  - lat_issue=1, lat_wd=12; next cycle raddr1=12 -> stallreq=1, busy=1.
  - Cycle with we=1, waddr=12, wdata=32'h55 -> stallreq=0, rdata1=32'h55.
  - Following cycle -> busy=0.
- Async reset mid-op: pending[12] set, pull rst low between clock edges -> busy=0 and stallreq=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/regfile_fwd_pkg.sv
// Shared register-file constants and the write-back triple type.
// Imported by the register file and its scoreboard.
package regfile_fwd_pkg;

   localparam int REG_NUM    = 32;
   localparam int REG_W      = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_W-1:0]      ZERO_WORD    = '0;
   localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

   typedef struct packed {
      logic                  wreg;
      logic [REG_ADDR_W-1:0] wd;
      logic [REG_W-1:0]      wdata;
   } wb_t;

   function automatic logic wb_hit(wb_t wb, logic [REG_ADDR_W-1:0] ra);
      return wb.wreg && (wb.wd == ra);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-writeback bits for long-latency ops.
// Set wins over a same-cycle clear; bit 0 never set.
module rf_scoreboard
   import regfile_fwd_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int NREG   = REG_NUM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic              hit1,
   output logic              hit2,
   output logic              busy
);

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;

   always_comb begin
      pending_nxt = pending;
      if (clr_en)
         pending_nxt[clr_addr] = 1'b0;
      if (set_en)
         pending_nxt[set_addr] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

   assign hit1 = pending[raddr1];
   assign hit2 = pending[raddr2];
   assign busy = |pending;

endmodule

// File: rtl/regfile_fwd.sv
// Integer register file with EX/MEM/WB forwarding into ID reads
// and a stall request for load-use and long-latency hazards.
module regfile_fwd
   import regfile_fwd_pkg::*;
#(
   parameter int DATA_W = REG_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int NREG   = REG_NUM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              ex_wreg,
   input  logic [ADDR_W-1:0] ex_wd,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              ex_is_load,
   input  logic              mem_wreg,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              lat_issue,
   input  logic [ADDR_W-1:0] lat_wd,
   output logic              stallreq,
   output logic              busy
);

   logic [DATA_W-1:0] regs [NREG];
   logic [1:0]        re;
   logic [ADDR_W-1:0] ra [2];
   logic [1:0]        sb_hit;
   logic [1:0]        stall;

   assign re    = {re2, re1};
   assign ra[0] = raddr1;
   assign ra[1] = raddr2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (we && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   rf_scoreboard #(
      .ADDR_W (ADDR_W),
      .NREG   (NREG)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (lat_issue),
      .set_addr (lat_wd),
      .clr_en   (we),
      .clr_addr (waddr),
      .raddr1   (raddr1),
      .raddr2   (raddr2),
      .hit1     (sb_hit[0]),
      .hit2     (sb_hit[1]),
      .busy     (busy)
   );

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [DATA_W-1:0] rd;
      logic              wb_match;
      logic              ld_use;

      assign wb_match = we && (waddr == ra[p]);
      assign ld_use   = ex_is_load && ex_wreg && (ex_wd == ra[p]);

      always_comb begin
         rd = '0;
         if (!rst || !re[p] || ra[p] == '0)
            rd = '0;
         else if (ex_wreg && ex_wd == ra[p])
            rd = ex_wdata;
         else if (mem_wreg && mem_wd == ra[p])
            rd = mem_wdata;
         else if (wb_match)
            rd = wdata;
         else
            rd = regs[ra[p]];
      end

      // r0 is never pending and a load into r0 is not a hazard
      assign stall[p] = rst && re[p] && (ra[p] != '0) &&
                        (ld_use || (sb_hit[p] && !wb_match));
   end

   assign rdata1   = g_port[0].rd;
   assign rdata2   = g_port[1].rd;
   assign stallreq = |stall;

endmodule

// File: tb/tb_regfile_fwd.sv
// Scoreboard bench for regfile_fwd: directed plan then random traffic
// checked against a set/array reference model.
module tb_regfile_fwd;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic        ex_wreg;
   logic [4:0]  ex_wd;
   logic [31:0] ex_wdata;
   logic        ex_is_load;
   logic        mem_wreg;
   logic [4:0]  mem_wd;
   logic [31:0] mem_wdata;
   logic        lat_issue;
   logic [4:0]  lat_wd;
   logic        stallreq;
   logic        busy;

   regfile_fwd dut (
      .clk        (clk),
      .rst        (rst),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .re1        (re1),
      .raddr1     (raddr1),
      .rdata1     (rdata1),
      .re2        (re2),
      .raddr2     (raddr2),
      .rdata2     (rdata2),
      .ex_wreg    (ex_wreg),
      .ex_wd      (ex_wd),
      .ex_wdata   (ex_wdata),
      .ex_is_load (ex_is_load),
      .mem_wreg   (mem_wreg),
      .mem_wd     (mem_wd),
      .mem_wdata  (mem_wdata),
      .lat_issue  (lat_issue),
      .lat_wd     (lat_wd),
      .stallreq   (stallreq),
      .busy       (busy)
   );

   typedef struct {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        stall;
      logic        busy;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] m_reg [32];
   bit          m_pend [int];

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, want, $time);
      end
   endtask

   function automatic logic [31:0] m_read(logic en, logic [4:0] a);
      if (!rst || !en || a == 0) return 32'h0;
      if (ex_wreg && ex_wd == a) return ex_wdata;
      if (mem_wreg && mem_wd == a) return mem_wdata;
      if (we && waddr == a) return wdata;
      return m_reg[a];
   endfunction

   function automatic logic m_stall(logic en, logic [4:0] a);
      if (!rst || !en || a == 0) return 1'b0;
      if (ex_is_load && ex_wreg && ex_wd == a) return 1'b1;
      return m_pend.exists(int'(a)) && !(we && waddr == a);
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
      m_pend.delete();
   endtask

   // One cycle: predict from current inputs, then apply the clock edge
   task automatic tick();
      exp_t e;
      if (!rst) m_clear();
      e.rd1   = m_read(re1, raddr1);
      e.rd2   = m_read(re2, raddr2);
      e.stall = m_stall(re1, raddr1) || m_stall(re2, raddr2);
      e.busy  = m_pend.num() > 0;
      exp_q.push_back(e);
      @(posedge clk);
      if (rst) begin
         if (we && waddr != 0) m_reg[waddr] = wdata;
         if (we) m_pend.delete(int'(waddr));
         if (lat_issue && lat_wd != 0) m_pend[int'(lat_wd)] = 1'b1;
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("rdata1", rdata1, e.rd1);
         check("rdata2", rdata2, e.rd2);
         check("stallreq", {31'b0, stallreq}, {31'b0, e.stall});
         check("busy", {31'b0, busy}, {31'b0, e.busy});
      end
   end

   task automatic idle();
      we = 0; waddr = 0; wdata = 0;
      re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
      ex_wreg = 0; ex_wd = 0; ex_wdata = 0; ex_is_load = 0;
      mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
      lat_issue = 0; lat_wd = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      rst = 1;
      m_clear();
      #1 rst = 0;
      tick();
      tick();
      rst = 1;
      re1 = 1; raddr1 = 5;
      #1 check("reset_rd", rdata1, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);
      tick();

      idle(); we = 1; waddr = 3; wdata = 32'hDEADBEEF;
      tick();
      idle(); re1 = 1; raddr1 = 3;
      #1 check("wr_rd", rdata1, 32'hDEADBEEF);
      tick();
      idle(); we = 1; waddr = 0; wdata = 32'h1234; re2 = 1; raddr2 = 0;
      tick();
      idle(); re2 = 1; raddr2 = 0;
      #1 check("r0", rdata2, 32'h0);
      tick();

      idle(); we = 1; waddr = 7; wdata = 1;
      tick();
      idle(); re1 = 1; raddr1 = 7;
      ex_wreg = 1; ex_wd = 7; ex_wdata = 2;
      mem_wreg = 1; mem_wd = 7; mem_wdata = 3;
      we = 1; waddr = 7; wdata = 4;
      #1 check("fwd_ex", rdata1, 32'd2);
      tick();
      ex_wreg = 0;
      #1 check("fwd_mem", rdata1, 32'd3);
      tick();
      mem_wreg = 0;
      #1 check("fwd_wb", rdata1, 32'd4);
      tick();

      idle(); ex_is_load = 1; ex_wreg = 1; ex_wd = 9; re2 = 1; raddr2 = 9;
      #1 check("ld_use", {31'b0, stallreq}, 32'd1);
      tick();
      re2 = 0;
      #1 check("ld_use_off", {31'b0, stallreq}, 32'd0);
      tick();

      idle(); lat_issue = 1; lat_wd = 12;
      tick();
      idle(); re1 = 1; raddr1 = 12;
      #1 check("sb_stall", {31'b0, stallreq}, 32'd1);
      check("sb_busy", {31'b0, busy}, 32'd1);
      tick();
      we = 1; waddr = 12; wdata = 32'h55;
      #1 check("sb_wb_stall", {31'b0, stallreq}, 32'd0);
      check("sb_wb_data", rdata1, 32'h55);
      tick();
      idle();
      #1 check("sb_clear", {31'b0, busy}, 32'd0);
      tick();

      lat_issue = 1; lat_wd = 12;
      tick();
      idle(); re1 = 1; raddr1 = 12;
      rst = 0;
      #1 check("async_busy", {31'b0, busy}, 32'd0);
      check("async_stall", {31'b0, stallreq}, 32'd0);
      check("async_rd", rdata1, 32'h0);
      m_clear();
      @(posedge clk);
      #1 rst = 1;

      for (int i = 0; i < 500; i++) begin
         rst        = ($urandom_range(0, 99) != 0);
         we         = 1'($urandom);
         waddr      = 5'($urandom_range(0, 7));
         wdata      = $urandom;
         re1        = ($urandom_range(0, 3) != 0);
         raddr1     = 5'($urandom_range(0, 7));
         re2        = ($urandom_range(0, 3) != 0);
         raddr2     = 5'($urandom_range(0, 7));
         ex_wreg    = 1'($urandom);
         ex_wd      = 5'($urandom_range(0, 7));
         ex_wdata   = $urandom;
         ex_is_load = ($urandom_range(0, 3) == 0);
         mem_wreg   = 1'($urandom);
         mem_wd     = 5'($urandom_range(0, 7));
         mem_wdata  = $urandom;
         lat_issue  = ($urandom_range(0, 3) == 0);
         lat_wd     = 5'($urandom_range(0, 7));
         tick();
      end
      idle();
      rst = 1;
      tick();
      @(posedge clk);
      #1;
      check("drain", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
